// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier slot:
// FSM states, register indices and CTRL/STATUS bit positions.
package seq_mult_pkg;

    localparam int W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] REG_A       = 5'd0;
    localparam logic [4:0] REG_B       = 5'd1;
    localparam logic [4:0] REG_CTRL    = 5'd2;
    localparam logic [4:0] REG_STATUS  = 5'd3;
    localparam logic [4:0] REG_PROD_LO = 5'd4;
    localparam logic [4:0] REG_PROD_HI = 5'd5;

    localparam int CTRL_START      = 0;
    localparam int CTRL_CLEAR_DONE = 1;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_OVF  = 2;

endpackage

// File: rtl/seq_mult_if.sv
// Register-slot bus of the multiplier: select, strobes, address, data.
interface seq_mult_if;
    import seq_mult_pkg::*;

    logic         cs;
    logic         read;
    logic         write;
    logic [4:0]   addr;
    logic [W-1:0] wr_data;
    logic [W-1:0] rd_data;

    modport master (output cs, read, write, addr, wr_data, input rd_data);
    modport slave  (input cs, read, write, addr, wr_data, output rd_data);

endinterface

// File: rtl/mult_add_stage.sv
// Combinational adder for the shift-add multiplier; the extra MSB is the carry-out.
module mult_add_stage #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   sum
);

    assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/seq_mult_core.sv
// Register-mapped unsigned 32x32 shift-add multiplier: one iteration per
// clock in RUN, 64-bit product exposed as PROD_HI/PROD_LO.
module seq_mult_core #(
    parameter int W = seq_mult_pkg::W
) (
    input logic       clk,
    input logic       reset,
    seq_mult_if.slave bus
);
    import seq_mult_pkg::*;

    state_t       state, next_state;
    logic [W-1:0] a_reg, b_reg;
    logic [W-1:0] mcand, mplier, acc;
    logic [W-1:0] prod_hi, prod_lo;
    logic [W-1:0] read_val, rd_q;
    logic [W-1:0] addend;
    logic [W:0]   sum;
    logic [5:0]   count;
    logic         done;
    logic         wr_en, rd_en, busy, ctrl_wr, start_ok, clear_ok, last;
    logic         iterate, finish, to_idle;

    assign wr_en    = bus.cs & bus.write;
    assign rd_en    = bus.cs & bus.read;
    assign busy     = (state == RUN);
    assign ctrl_wr  = wr_en && (bus.addr == REG_CTRL) && !busy;
    assign start_ok = ctrl_wr && bus.wr_data[CTRL_START];
    assign clear_ok = ctrl_wr && bus.wr_data[CTRL_CLEAR_DONE];
    assign last     = (count == 6'(W - 1));
    assign addend   = mplier[0] ? mcand : '0;
    assign bus.rd_data = rd_q;

    mult_add_stage #(.W(W)) u_add (
        .a  (acc),
        .b  (addend),
        .sum(sum)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        next_state = state;
        iterate    = 1'b0;
        finish     = 1'b0;
        to_idle    = 1'b0;
        unique case (state)
            IDLE: if (start_ok) next_state = RUN;
            RUN: begin
                iterate = 1'b1;
                if (last) begin
                    finish     = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if (start_ok) begin
                    next_state = RUN;
                end else if (clear_ok) begin
                    next_state = IDLE;
                    to_idle    = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        read_val = '0;
        case (bus.addr)
            REG_A:       read_val = a_reg;
            REG_B:       read_val = b_reg;
            REG_STATUS: begin
                read_val[STAT_BUSY] = busy;
                read_val[STAT_DONE] = done;
                read_val[STAT_OVF]  = (prod_hi != '0);
            end
            REG_PROD_LO: read_val = prod_lo;
            REG_PROD_HI: read_val = prod_hi;
            default:     read_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: A/B are plain flops rather than a memory array, so they reset with everything else.
            a_reg   <= '0;
            b_reg   <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
            prod_hi <= '0;
            prod_lo <= '0;
            done    <= 1'b0;
            rd_q    <= '0;
        end else begin
            // NOTE: non-blocking updates mean a same-cycle read captures the pre-write register value.
            if (wr_en && !busy) begin
                if (bus.addr == REG_A) a_reg <= bus.wr_data;
                if (bus.addr == REG_B) b_reg <= bus.wr_data;
            end

            if (start_ok) begin
                mcand  <= a_reg;
                mplier <= b_reg;
                acc    <= '0;
                count  <= '0;
                done   <= 1'b0;
            end else if (iterate) begin
                // {carry, acc, mplier} shifted right by one
                acc    <= sum[W:1];
                mplier <= {sum[0], mplier[W-1:1]};
                count  <= count + 6'd1;
                if (finish) begin
                    prod_hi <= sum[W:1];
                    prod_lo <= {sum[0], mplier[W-1:1]};
                    done    <= 1'b1;
                end
            end else if (to_idle) begin
                done <= 1'b0;
            end

            if (rd_en) rd_q <= read_val;
        end
    end

endmodule

// File: tb/tb_seq_mult_core.sv
// Self-checking bench for seq_mult_core: directed register-level scenarios plus
// random bus traffic compared every cycle against a product/countdown model.
module tb_seq_mult_core;
    import seq_mult_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    seq_mult_if bus();

    seq_mult_core #(.W(32)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Model: registers as plain variables; a started multiply delivers a*b
    // 32 edges after the start write and reads as busy until then.
    logic [31:0] m_a, m_b, m_hi, m_lo, m_exp, m_rv;
    logic [63:0] m_prod;
    logic        m_done, m_pend, m_busy;
    int          m_left;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_a = 0; m_b = 0; m_hi = 0; m_lo = 0; m_exp = 0;
            m_prod = 0; m_done = 0; m_pend = 0; m_left = 0;
        end else begin
            m_busy = m_pend;
            if (bus.cs && bus.read) begin
                case (bus.addr)
                    REG_A:       m_rv = m_a;
                    REG_B:       m_rv = m_b;
                    REG_STATUS:  m_rv = {29'd0, m_hi != 0, m_done, m_busy};
                    REG_PROD_LO: m_rv = m_lo;
                    REG_PROD_HI: m_rv = m_hi;
                    default:     m_rv = 0;
                endcase
                m_exp = m_rv;
            end
            if (m_pend) begin
                m_left--;
                if (m_left == 0) begin
                    {m_hi, m_lo} = m_prod;
                    m_done = 1;
                    m_pend = 0;
                end
            end
            if (bus.cs && bus.write && !m_busy) begin
                case (bus.addr)
                    REG_A: m_a = bus.wr_data;
                    REG_B: m_b = bus.wr_data;
                    REG_CTRL: begin
                        if (bus.wr_data[0]) begin
                            m_prod = 64'(m_a) * 64'(m_b);
                            m_pend = 1;
                            m_left = 32;
                            m_done = 0;
                        end else if (bus.wr_data[1]) begin
                            m_done = 0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) check("rd_data_vs_model", {32'd0, bus.rd_data}, {32'd0, m_exp});
    end

    task automatic bus_idle();
        bus.cs = 0; bus.read = 0; bus.write = 0; bus.addr = 0; bus.wr_data = 0;
    endtask

    task automatic bus_op(input logic c, input logic r, input logic w,
                          input logic [4:0] a, input logic [31:0] d);
        bus.cs = c; bus.read = r; bus.write = w; bus.addr = a; bus.wr_data = d;
        @(posedge clk);
        @(negedge clk);
        bus_idle();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus_op(1, 0, 1, a, d);
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        bus_op(1, 1, 0, a, 0);
        d = bus.rd_data;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) bus_op(0, 0, 0, 0, 0);
    endtask

    // Polls STATUS; seen is the edge on which done first read back as 1.
    task automatic wait_done(input string name, output int seen, output int busy_cnt,
                             output logic [31:0] status);
        seen = -1;
        busy_cnt = 0;
        status = 0;
        for (int i = 0; i < 40; i++) begin
            rd(REG_STATUS, status);
            if (status[STAT_BUSY]) busy_cnt++;
            if (status[STAT_DONE]) begin
                seen = cyc;
                break;
            end
        end
        if (seen < 0) begin
            checks++;
            failures++;
            $display("FAIL %s done never seen within 40 reads, status=%0h", name, status);
        end
    endtask

    logic [31:0] d, st;
    int          n, seen, bcnt;

    initial begin
        bus_idle();
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;

        for (int a = 0; a < 6; a++) begin
            rd(5'(a), d);
            check("reset_value", {32'd0, d}, 64'd0);
        end

        rd(5'd7, d);
        check("unmapped_addr7", {32'd0, d}, 64'd0);
        wr(REG_A, 32'hDEADBEEF);
        rd(REG_A, d);
        check("a_readback", {32'd0, d}, 64'hDEADBEEF);
        bus_op(1, 1, 1, REG_A, 32'h0000_1234);
        check("read_during_write_old", {32'd0, bus.rd_data}, 64'hDEADBEEF);
        rd(REG_A, d);
        check("read_after_write_new", {32'd0, d}, 64'h1234);

        // 3 * 5: busy on 32 reads, done first read on edge N+33
        wr(REG_A, 3);
        wr(REG_B, 5);
        wr(REG_CTRL, 32'h1);
        n = cyc;
        wait_done("mul_3x5", seen, bcnt, st);
        check("3x5_busy_cycles", 64'(bcnt), 64'd32);
        check("3x5_done_edge", 64'(seen - n), 64'd33);
        check("3x5_status", {32'd0, st}, 64'h2);
        rd(REG_PROD_LO, d);
        check("3x5_prod_lo", {32'd0, d}, 64'd15);
        rd(REG_PROD_HI, d);
        check("3x5_prod_hi", {32'd0, d}, 64'd0);

        // all-ones squared
        wr(REG_A, 32'hFFFFFFFF);
        wr(REG_B, 32'hFFFFFFFF);
        wr(REG_CTRL, 32'h1);
        wait_done("mul_ones", seen, bcnt, st);
        check("ones_status_ovf", {32'd0, st}, 64'h6);
        rd(REG_PROD_LO, d);
        check("ones_prod_lo", {32'd0, d}, 64'h1);
        rd(REG_PROD_HI, d);
        check("ones_prod_hi", {32'd0, d}, 64'hFFFFFFFE);

        // multiply by zero, then clear_done
        wr(REG_A, 32'h12345678);
        wr(REG_B, 0);
        wr(REG_CTRL, 32'h1);
        wait_done("mul_zero", seen, bcnt, st);
        check("zero_status", {32'd0, st}, 64'h2);
        wr(REG_CTRL, 32'h2);
        rd(REG_STATUS, d);
        check("clear_done_status", {32'd0, d}, 64'h0);
        rd(REG_PROD_LO, d);
        check("clear_done_prod_lo", {32'd0, d}, 64'h0);

        // writes and start while busy are ignored
        wr(REG_A, 7);
        wr(REG_B, 6);
        wr(REG_CTRL, 32'h1);
        n = cyc;
        idle_cycles(4);
        wr(REG_A, 100);
        wr(REG_CTRL, 32'h1);
        wait_done("mul_7x6", seen, bcnt, st);
        check("7x6_done_edge", 64'(seen - n), 64'd33);
        rd(REG_PROD_LO, d);
        check("7x6_prod_lo", {32'd0, d}, 64'd42);
        rd(REG_A, d);
        check("7x6_a_kept", {32'd0, d}, 64'd7);
        rd(REG_B, d);
        check("7x6_b_kept", {32'd0, d}, 64'd6);

        // start and clear_done together: start wins
        wr(REG_CTRL, 32'h3);
        rd(REG_STATUS, d);
        check("start_wins_busy", {32'd0, d}, 64'h1);
        wait_done("start_wins", seen, bcnt, st);

        // reset mid-run
        wr(REG_A, 32'h10000);
        wr(REG_B, 32'h10000);
        wr(REG_CTRL, 32'h1);
        idle_cycles(9);
        #2 reset = 1;
        #3 reset = 0;
        @(negedge clk);
        rd(REG_STATUS, d);
        check("reset_mid_status", {32'd0, d}, 64'h0);
        rd(REG_PROD_HI, d);
        check("reset_mid_prod_hi", {32'd0, d}, 64'h0);
        rd(REG_PROD_LO, d);
        check("reset_mid_prod_lo", {32'd0, d}, 64'h0);
        rd(REG_A, d);
        check("reset_mid_a", {32'd0, d}, 64'h0);
        wr(REG_A, 32'h10000);
        wr(REG_B, 32'h10000);
        wr(REG_CTRL, 32'h1);
        wait_done("mul_2p32", seen, bcnt, st);
        rd(REG_PROD_HI, d);
        check("2p32_prod_hi", {32'd0, d}, 64'h1);
        rd(REG_PROD_LO, d);
        check("2p32_prod_lo", {32'd0, d}, 64'h0);

        // random traffic; the per-cycle compare against the model does the checking
        for (int i = 0; i < 1500; i++) begin
            logic        c, r, w;
            logic [4:0]  a;
            logic [31:0] v;
            int          kind;
            c = ($urandom_range(0, 9) != 0);
            kind = $urandom_range(0, 9);
            r = (kind < 5) || (kind == 9);
            w = (kind >= 5);
            a = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(6, 31)) : 5'($urandom_range(0, 5));
            if (w && $urandom_range(0, 3) == 0) a = REG_CTRL;
            case ($urandom_range(0, 5))
                0:       v = 32'hFFFFFFFF;
                1:       v = 32'h0;
                2:       v = 32'($urandom_range(0, 3));
                default: v = $urandom;
            endcase
            if (a == REG_CTRL && $urandom_range(0, 2) != 0) v = 32'($urandom_range(0, 3));
            bus_op(c, r, w, a, v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
